// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch unit: FSM state encoding and
// the default done-timeout.
package bitty_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_MEM_WAIT = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_EXEC     = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_FETCH    = ST_FETCH,
    S_MEM_WAIT = ST_MEM_WAIT,
    S_ISSUE    = ST_ISSUE,
    S_EXEC     = ST_EXEC,
    S_HALT     = ST_HALT,
    S_ERROR    = ST_ERROR
  } state_t;

endpackage

// File: rtl/bitty_watchdog.sv
// Cycle counter guarding the core's done response. expired is raised on the
// TIMEOUT-th consecutive enabled cycle, so the caller can act on that edge.
module bitty_watchdog
  import bitty_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch sequencer: reads one instruction per step from a
// registered-read memory, hands it to the core and waits for done.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              error
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_q;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;

  // done only counts while the core is executing; everywhere else it is noise.
  assign wd_clear  = (state == S_ISSUE);
  assign wd_enable = (state == S_EXEC) && !done;

  bitty_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // NOTE: the instruction register is a single flop bank, not a memory, so it
  // is cleared by reset like the rest of the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= 16'h0000;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH:    state <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          instr_q <= mem_data;
          state   <= S_ISSUE;
        end
        S_ISSUE:    state <= S_EXEC;
        S_EXEC: begin
          // A done arriving on the expiry cycle still completes normally.
          if (done) begin
            if (pc == last_addr) begin
              state <= S_HALT;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else if (wd_expired) begin
            state <= S_ERROR;
          end
        end
        S_ERROR:    state <= S_ERROR;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes, so they are one cycle wide by construction.
  assign mem_rd      = (state == S_FETCH);
  assign run         = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign error       = (state == S_ERROR);
  assign mem_addr    = pc;
  assign pc_out      = pc;
  assign instruction = instr_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: randomized programs and done
// delays compared against a program-level model of fetch/issue/halt.
module tb_bitty_fetch_unit;

  localparam int AW    = 2;
  localparam int TO    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_data;
  logic [15:0]   instruction;
  logic          run;
  logic [AW-1:0] pc_out;
  logic          halted;
  logic          error;

  logic [15:0]   mem [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  bitty_fetch_unit #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .last_addr   (last_addr),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .pc_out      (pc_out),
    .halted      (halted),
    .error       (error)
  );

  // Registered-read memory: data is only meaningful the cycle after mem_rd.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 16'($urandom);

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if (mem_rd === 1'b1 && run === 1'b1) begin
        n_fail++;
        $display("FAIL rd_run_overlap: mem_rd=%0b run=%0b, required never both high", mem_rd, run);
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  task automatic apply_reset();
    start = 1'b0;
    done  = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Expect fetch, memory wait, then issue on exactly the 3rd cycle after the
  // triggering start/done.
  task automatic wait_issue(input string name, input int exp_pc);
    logic [AW-1:0] pc_m;
    pc_m = AW'(exp_pc);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      done  = 1'b0;
      n_checks++;
      if (k == 1) begin
        if (mem_rd !== 1'b1 || mem_addr !== pc_m || halted !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fetch: mem_rd=%0b mem_addr=%0d halted=%0b, required 1/%0d/0",
                   name, mem_rd, mem_addr, halted, pc_m);
        end
      end else if (k == 2) begin
        if (mem_rd !== 1'b0 || run !== 1'b0) begin
          n_fail++;
          $display("FAIL %s mem_wait: mem_rd=%0b run=%0b, required 0/0", name, mem_rd, run);
        end
      end else begin
        if (run !== 1'b1 || pc_out !== pc_m || instruction !== mem[pc_m]) begin
          n_fail++;
          $display("FAIL %s issue: run=%0b pc_out=%0d instr=%h, required 1/%0d/%h",
                   name, run, pc_out, instruction, pc_m, mem[pc_m]);
        end
      end
    end
  endtask

  // Runs a program from address 0. The model issues pc 0,1,2.. (mod DEPTH)
  // and halts on the first instruction whose pc equals last_addr at done time.
  task automatic exec_program(input string name, input logic [AW-1:0] last,
                              input int dmin, input int dmax,
                              input bit wrap_mode, input int abort_pc);
    int          exp_pc;
    int          d;
    bit          fin;
    logic [15:0] exp_instr;
    exp_pc    = 0;
    fin       = 1'b0;
    last_addr = wrap_mode ? AW'(2) : last;
    start     = 1'b1;
    for (int i = 0; i < 16 && !fin; i++) begin
      wait_issue(name, exp_pc);
      if (exp_pc == abort_pc) return;
      if (wrap_mode) last_addr = (i < 5) ? AW'((exp_pc + 2) % DEPTH) : AW'(1);
      exp_instr = mem[exp_pc];
      d = $urandom_range(dmax, dmin);
      for (int k = 1; k <= d; k++) begin
        @(negedge clk);
        n_checks++;
        if (run !== 1'b0 || mem_rd !== 1'b0 || error !== 1'b0 ||
            instruction !== exp_instr || pc_out !== AW'(exp_pc)) begin
          n_fail++;
          $display("FAIL %s exec_hold: run=%0b mem_rd=%0b error=%0b instr=%h pc=%0d, required 0/0/0/%h/%0d",
                   name, run, mem_rd, error, instruction, pc_out, exp_instr, exp_pc);
        end
      end
      done = 1'b1;
      fin  = (AW'(exp_pc) == last_addr);
      if (!fin) exp_pc = (exp_pc + 1) % DEPTH;
    end
    @(negedge clk);
    done = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || pc_out !== AW'(exp_pc) || run !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s halt: halted=%0b pc_out=%0d run=%0b error=%0b, required 1/%0d/0/0",
               name, halted, pc_out, run, error, exp_pc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rd !== 1'b0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL %s halt_hold: mem_rd=%0b halted=%0b, required 0/1", name, mem_rd, halted);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (mem_addr !== '0 || pc_out !== '0 || instruction !== 16'h0000 || run !== 1'b0 ||
        mem_rd !== 1'b0 || halted !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: addr=%0d pc=%0d instr=%h run=%0b rd=%0b halted=%0b error=%0b, required all zero",
               name, mem_addr, pc_out, instruction, run, mem_rd, halted, error);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; done = 1'b0; last_addr = '0; reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_all_zero("reset_idle");
    end
  endtask

  task automatic test_directed_program();
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hdead; mem[3] = 16'hbeef;
    exec_program("directed", 2'd1, 2, 2, 1'b0, -1);
  endtask

  task automatic test_random_programs();
    for (int it = 0; it < 6; it++) begin
      fill_mem();
      exec_program("random", AW'($urandom_range(DEPTH - 1, 0)), 1, TO, 1'b0, -1);
    end
  endtask

  task automatic test_timeout_boundary();
    fill_mem();
    exec_program("done_at_limit", 2'd2, TO, TO, 1'b0, -1);
  endtask

  task automatic test_done_ignored();
    apply_reset();
    fill_mem();
    last_addr = 2'd3;
    done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rd !== 1'b0 || run !== 1'b0 || pc_out !== '0) begin
        n_fail++;
        $display("FAIL done_idle: mem_rd=%0b run=%0b pc=%0d, required 0/0/0", mem_rd, run, pc_out);
      end
    end
    start = 1'b1;
    // done stays high through fetch, wait and issue, and drops before EXEC samples it.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (run !== 1'b1 || pc_out !== '0) begin
      n_fail++;
      $display("FAIL done_issue: run=%0b pc=%0d, required 1/0", run, pc_out);
    end
    @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rd !== 1'b0 || run !== 1'b0 || pc_out !== '0) begin
        n_fail++;
        $display("FAIL done_ignored_exec: mem_rd=%0b run=%0b pc=%0d, required 0/0/0", mem_rd, run, pc_out);
      end
    end
    done = 1'b1;
    wait_issue("done_then_next", 1);
    apply_reset();
  endtask

  task automatic test_timeout();
    fill_mem();
    last_addr = 2'd3;
    start = 1'b1;
    wait_issue("timeout", 0);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (error !== (k == TO + 1) || run !== 1'b0 || mem_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: error=%0b run=%0b mem_rd=%0b, required %0b/0/0",
                 k, error, run, mem_rd, (k == TO + 1));
      end
    end
    start = 1'b1;
    done  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      done  = 1'b0;
      n_checks++;
      if (error !== 1'b1 || mem_rd !== 1'b0 || run !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL error_sticky: error=%0b mem_rd=%0b run=%0b halted=%0b, required 1/0/0/0",
                 error, mem_rd, run, halted);
      end
    end
    apply_reset();
    #1 check_all_zero("error_reset");
  endtask

  task automatic test_reset_mid_exec();
    fill_mem();
    exec_program("to_addr3", 2'd3, 1, 3, 1'b0, 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid_exec");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (run !== 1'b0 || mem_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset_quiet: run=%0b mem_rd=%0b, required 0/0", run, mem_rd);
      end
    end
    exec_program("restart", 2'd1, 1, 4, 1'b0, -1);
  endtask

  task automatic test_wrap();
    fill_mem();
    exec_program("wrap", 2'd1, 1, 3, 1'b1, -1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_directed_program();
    test_random_programs();
    test_timeout_boundary();
    test_done_ignored();
    test_timeout();
    test_reset_mid_exec();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
